// File: rtl/mem_req_master.sv
// mem_req_master: single-outstanding request initiator between the core and the single-port memory
module mem_req_master #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_we,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
    output logic                  cpu_rsp_valid,
    output logic [DATA_WIDTH-1:0] cpu_rsp_rdata,
    output logic                  cpu_rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_req_valid,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wdata_oe,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_data_valid,
    output logic                  busy
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  active;

    // Sequence one request through issue, wait-for-completion (with timeout) and response
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req_valid) begin
                        state   <= ISSUE;
                        we_q    <= cpu_req_we;
                        addr_q  <= cpu_req_addr;
                        wdata_q <= cpu_req_wdata;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: begin
                    if (mem_data_valid) begin
                        state   <= RESP;
                        rdata_q <= we_q ? '0 : mem_rdata;
                        err_q   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(TIMEOUT - 1)) begin
                            state   <= RESP;
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from state and latched request only, so cpu_* never reaches mem_* combinationally
    assign active        = (state == ISSUE) || (state == WAIT);
    assign cpu_req_ready = state == IDLE;
    assign busy          = state != IDLE;
    assign mem_req_valid = state == ISSUE;
    assign mem_addr      = active ? addr_q : '0;
    assign mem_we        = active & we_q;
    assign mem_wdata_oe  = (state == ISSUE) & we_q;
    assign mem_wdata     = mem_wdata_oe ? wdata_q : '0;
    assign cpu_rsp_valid = state == RESP;
    assign cpu_rsp_rdata = cpu_rsp_valid ? rdata_q : '0;
    assign cpu_rsp_err   = cpu_rsp_valid & err_q;
endmodule

// File: doc/mem_req_master.md
Name: mem_req_master

Overview:
Initiator side of the single-port memory request interface. It accepts one load, store or fetch request at a time from the core over a valid/ready handshake and drives addr/req_valid/WE/write data toward the memory. It then waits for the memory's data_valid and returns a single-cycle response to the core. Sits between the CPU pipeline (fetch/LSU) and the memory block; the top level resolves mem_wdata/mem_wdata_oe onto the shared bidirectional Data bus.

Parameters:
ADDR_WIDTH, 3, memory word-address width (matches an 8-deep memory)
DATA_WIDTH, 32, data word width
TIMEOUT, 15, maximum WAIT cycles without data_valid before an error response; legal range 1..255

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high
cpu_req_valid  input  1  core request present
cpu_req_ready  output  1  master can accept a request
cpu_req_we  input  1  1 = write, 0 = read
cpu_req_addr  input  ADDR_WIDTH  word address
cpu_req_wdata  input  DATA_WIDTH  store data
cpu_rsp_valid  output  1  one-cycle response pulse
cpu_rsp_rdata  output  DATA_WIDTH  read data (0 for writes and errors)
cpu_rsp_err  output  1  timeout flag, qualified by cpu_rsp_valid
mem_addr  output  ADDR_WIDTH  to memory addr
mem_req_valid  output  1  to memory req_valid
mem_we  output  1  to memory WE
mem_wdata  output  DATA_WIDTH  write data toward the Data bus
mem_wdata_oe  output  1  drive enable for the Data bus
mem_rdata  input  DATA_WIDTH  Data bus as seen by the master
mem_data_valid  input  1  memory completion status
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, active-high, overrides everything): state=IDLE, timeout counter=0. All outputs 0 except cpu_req_ready=1. Request registers cleared.
- States: IDLE, ISSUE, WAIT, RESP. One request outstanding at most.
- IDLE:
  - cpu_req_ready=1.
  - When cpu_req_valid=1 at a clock edge, latch we/addr/wdata and move to ISSUE.
  - cpu_req_ready is 0 in all other states; a valid seen outside IDLE is not accepted.
- ISSUE (exactly 1 cycle):
  - mem_req_valid=1, mem_addr and mem_we from the latched values.
  - For writes: mem_wdata_oe=1 and mem_wdata=latched wdata. For reads: mem_wdata_oe=0.
  - Next state: WAIT; counter cleared.
- WAIT:
  - mem_req_valid=0, mem_wdata_oe=0; mem_addr and mem_we held stable.
  - If mem_data_valid=1: capture mem_rdata (reads only; writes capture 0), err=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, go to RESP with err=1 and rdata=0.
  - mem_data_valid is sampled only in WAIT. A level already high from an earlier transaction completes the current one; the memory's fixed 1-cycle latency makes this correct.
- RESP (exactly 1 cycle):
  - cpu_rsp_valid=1, with cpu_rsp_rdata and cpu_rsp_err from the captured values.
  - No backpressure; next state IDLE.
  - cpu_rsp_rdata/cpu_rsp_err are 0 whenever cpu_rsp_valid=0.
- Latency with a 1-cycle memory:
  - Accept edge E. ISSUE in cycle E+1. WAIT in cycle E+2 with data_valid high.
  - cpu_rsp_valid in cycle E+3.
  - Throughput: one request per 4 cycles; a request held valid during RESP is accepted on the edge after RESP ends.
- Counter width is ceil(log2(TIMEOUT+1)); no wrap, because it saturates into RESP.
- Reset mid-transaction: the transaction is abandoned and no response is issued. mem_req_valid and mem_wdata_oe drop in the cycle after the reset edge.
- All outputs are registered or decoded from state only; there is no combinational path from cpu_* inputs to mem_* outputs.

Test Plan:
- Read after reset, memory word 2 = 32'h00730e33: request addr=2, we=0 -> mem_req_valid pulse 1 cycle with mem_addr=2, mem_we=0, mem_wdata_oe=0. cpu_rsp_valid 3 cycles after accept, rdata=32'h00730e33, err=0.
- Write addr=6, wdata=32'hDEADBEEF, then read addr=6 -> ISSUE cycle shows mem_wdata_oe=1 and mem_wdata=32'hDEADBEEF. Write response has rdata=0, err=0. Read returns 32'hDEADBEEF.
- Back-to-back: cpu_req_valid held high for reads of addr 0 then 1 -> cpu_req_ready low in ISSUE/WAIT/RESP. Accepts are exactly 4 cycles apart. Responses are 32'h00a38313, then 32'h01400393.
- Timeout: memory model never asserts data_valid, TIMEOUT=15 -> after 15 WAIT cycles, cpu_rsp_valid=1, err=1, rdata=0. The next request is then accepted normally.
- Reset asserted during WAIT -> next cycle state IDLE, cpu_req_ready=1, busy=0, and no cpu_rsp_valid pulse ever appears for the abandoned request.
- Request asserted during RESP -> not accepted in RESP, accepted on the following IDLE edge, with the correct response 3 cycles later.
